// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver for the MMIO keyboard registers.
// It synchronises the pad clock and data and deframes 11-bit device-to-host frames.
// Accepted scan-code bytes are queued in a small FIFO for the MMIO block, which
// reads the ready flag at 0xfbadbeee and the data at 0xfbadbeef.
// Optional build macro: KBD_PARITY_CHECK_EN. When it is defined, a frame whose odd
// parity fails is rejected. When it is undefined, the parity bit is received and ignored.
module ps2_kbd_rx #(
    parameter int FIFO_AW        = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       read_enable,
    output logic       ready,
    output logic       overflow,
    output logic [7:0] data,
    output logic       frame_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    // Bit positions within a frame. The bit counter walks through them on each falling ps2_clk edge.
    localparam logic [3:0] BIT_START     = 4'd0;
    localparam logic [3:0] BIT_DATA_LAST = 4'd8;
    localparam logic [3:0] BIT_PARITY    = 4'd9;
    localparam logic [3:0] BIT_STOP      = 4'd10;

    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Synchroniser stages. They reset to 1 because the idle PS/2 bus is high.
    logic clkS1_q, clkS2_q, clkS3_q;
    logic dataS1_q, dataS2_q;
    logic fallEdge;

    // Deframer state
    logic [3:0]    bitCnt_q,   bitCnt_d;
    logic [7:0]    shift_q,    shift_d;
    logic          startBit_q, startBit_d;
    logic          parity_q,   parity_d;
    logic [TW-1:0] timeout_q,  timeout_d;
    logic          pushReq_q,  pushReq_d;
    logic [7:0]    pushData_q, pushData_d;
    logic          frameErr_q, frameErr_d;
    logic          parityOk;
    logic          frameOk;

    // FIFO state. Each pointer carries an extra wrap bit so that full can be told apart from empty.
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW:0]   wrPtr_q, wrPtr_d;
    logic [FIFO_AW:0]   rdPtr_q, rdPtr_d;
    logic               overflow_q, overflow_d;
    logic               fifoEmpty;
    logic               fifoFull;
    logic               doPush;
    logic               doPop;
    logic               dropByte;

    // Bring the asynchronous pad signals into the clk domain.
    // ps2_clk gets an extra stage so that its falling edge can be detected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkS1_q  <= 1'b1;
            clkS2_q  <= 1'b1;
            clkS3_q  <= 1'b1;
            dataS1_q <= 1'b1;
            dataS2_q <= 1'b1;
        end else begin
            clkS1_q  <= ps2_clk;
            clkS2_q  <= clkS1_q;
            clkS3_q  <= clkS2_q;
            dataS1_q <= ps2_data;
            dataS2_q <= dataS1_q;
        end
    end

    assign fallEdge = ~clkS2_q & clkS3_q;

    // Odd parity covers the eight data bits plus the parity bit.
    // Without the check, the received parity bit has no effect on acceptance.
    always_comb begin
`ifdef KBD_PARITY_CHECK_EN
        parityOk = ^{shift_q, parity_q};
`else
        parityOk = 1'b1;
`endif
    end

    // A frame is accepted on the stop-bit edge when the start bit was 0, the stop bit is 1, and parity is acceptable.
    assign frameOk = ~startBit_q & dataS2_q & parityOk;

    // Deframer next state: step the bit counter on falling edges, and abandon a stalled partial frame after the idle timeout.
    always_comb begin
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        startBit_d = startBit_q;
        parity_d   = parity_q;
        timeout_d  = timeout_q;
        pushReq_d  = 1'b0;
        pushData_d = pushData_q;
        frameErr_d = 1'b0;
        if (fallEdge) begin
            timeout_d = '0;
            if (bitCnt_q == BIT_START) begin
                startBit_d = dataS2_q;
                bitCnt_d   = bitCnt_q + 4'd1;
            end else if (bitCnt_q <= BIT_DATA_LAST) begin
                shift_d  = {dataS2_q, shift_q[7:1]};
                bitCnt_d = bitCnt_q + 4'd1;
            end else if (bitCnt_q == BIT_PARITY) begin
                parity_d = dataS2_q;
                bitCnt_d = BIT_STOP;
            end else begin
                bitCnt_d = BIT_START;
                if (frameOk) begin
                    pushReq_d  = 1'b1;
                    pushData_d = shift_q;
                end else begin
                    frameErr_d = 1'b1;
                end
            end
        end else if (bitCnt_q != BIT_START) begin
            if (timeout_q == TIMEOUT_LAST) begin
                bitCnt_d  = BIT_START;
                timeout_d = '0;
            end else begin
                timeout_d = timeout_q + 1'b1;
            end
        end
    end

    // Deframer registers. The push request is registered, so the FIFO write lands one cycle after the stop-bit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitCnt_q   <= BIT_START;
            shift_q    <= 8'h00;
            startBit_q <= 1'b0;
            parity_q   <= 1'b0;
            timeout_q  <= '0;
            pushReq_q  <= 1'b0;
            pushData_q <= 8'h00;
            frameErr_q <= 1'b0;
        end else begin
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            startBit_q <= startBit_d;
            parity_q   <= parity_d;
            timeout_q  <= timeout_d;
            pushReq_q  <= pushReq_d;
            pushData_q <= pushData_d;
            frameErr_q <= frameErr_d;
        end
    end

    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[FIFO_AW-1:0] == rdPtr_q[FIFO_AW-1:0]) &&
                       (wrPtr_q[FIFO_AW] != rdPtr_q[FIFO_AW]);

    // A pop on an empty FIFO is ignored.
    // A push into a full FIFO still succeeds if a pop frees the head slot in the same cycle.
    always_comb begin
        doPop      = read_enable & ~fifoEmpty;
        doPush     = pushReq_q & (~fifoFull | doPop);
        dropByte   = pushReq_q & fifoFull & ~doPop;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        overflow_d = overflow_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (dropByte) begin
            overflow_d = 1'b1;
        end else if (read_enable) begin
            overflow_d = 1'b0;
        end
    end

    // FIFO pointers and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage needs no reset, because the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q[FIFO_AW-1:0]] <= pushData_q;
        end
    end

    assign ready     = ~fifoEmpty;
    assign data      = fifoEmpty ? 8'h00 : mem[rdPtr_q[FIFO_AW-1:0]];
    assign overflow  = overflow_q;
    assign frame_err = frameErr_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx.
// A table of single frames with expected outputs is applied first.
// Hand-written sequences then cover FIFO ordering, overflow, timeout and mid-frame reset.
// Expectations follow KBD_PARITY_CHECK_EN when it is defined.
module tb_ps2_kbd_rx;

    localparam int TIMEOUT = 300;
    localparam int HALF    = 8;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       read_enable;
    logic       ready;
    logic       overflow;
    logic [7:0] data;
    logic       frame_err;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic [7:0] code;
        logic       flipParity;
        logic       badStart;
        logic       badStop;
        logic       expErr;
        logic       expReady;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs [8];

    logic       e3, e4, r4, o4;
    logic [7:0] d4;
    logic [7:0] drainExp [8];

    ps2_kbd_rx #(
        .FIFO_AW(3),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .read_enable(read_enable),
        .ready(ready),
        .overflow(overflow),
        .data(data),
        .frame_err(frame_err)
    );

    // Free-running system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and count the result.
    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one full frame, then sample frame_err 3 and 4 clk after the stop edge, and ready/data/overflow 4 clk after it.
    // The optional pop is timed to land on the same edge as the FIFO push.
    task automatic applyStimulus(input logic [7:0] code, input logic flipPar, input logic badStart,
                                 input logic badStop, input logic popAtPush,
                                 output logic errAt3, output logic errAt4, output logic readyAt4,
                                 output logic ovfAt4, output logic [7:0] dataAt4);
        logic [10:0] frame;
        frame = {~badStop, (~^code) ^ flipPar, code, badStart};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ps2_data = frame[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i < 10) begin
                repeat (HALF) @(negedge clk);
                ps2_clk = 1'b1;
            end
        end
        repeat (3) @(negedge clk);
        errAt3 = frame_err;
        if (popAtPush) read_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'b0;
        errAt4   = frame_err;
        readyAt4 = ready;
        dataAt4  = data;
        ovfAt4   = overflow;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    // Drive only the first n bits of a frame, leaving the bus idle afterwards.
    task automatic sendPartial(input logic [7:0] code, input int n);
        logic [10:0] frame;
        frame = {1'b1, ~^code, code, 1'b0};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = frame[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
    endtask

    // Check that the head byte is the expected one, then pop it.
    task automatic popExpect(input string name, input logic [7:0] exp);
        @(negedge clk);
        checkOutput({name, " ready"}, ready, 8'h01);
        checkOutput(name, data, exp);
        read_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        ps2_clk     = 1'b1;
        ps2_data    = 1'b1;
        read_enable = 1'b0;

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C};
        vecs[1] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0};
        vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
`ifdef KBD_PARITY_CHECK_EN
        vecs[5] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
`else
        vecs[5] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C};
`endif
        vecs[6] = '{8'h29, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[7] = '{8'h29, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};

        // Reset state, both during reset and after release
        repeat (3) @(negedge clk);
        checkOutput("rst ready", ready, 8'h00);
        checkOutput("rst overflow", overflow, 8'h00);
        checkOutput("rst data", data, 8'h00);
        checkOutput("rst frame_err", frame_err, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-rst ready", ready, 8'h00);

        // read_enable on an empty FIFO is ignored
        read_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'b0;
        checkOutput("empty pop ready", ready, 8'h00);
        checkOutput("empty pop data", data, 8'h00);
        checkOutput("empty pop overflow", overflow, 8'h00);

        // Table-driven single frames, each into an empty FIFO
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].code, vecs[i].flipParity, vecs[i].badStart, vecs[i].badStop,
                          1'b0, e3, e4, r4, o4, d4);
            checkOutput($sformatf("vec%0d frame_err@3", i), e3, vecs[i].expErr);
            checkOutput($sformatf("vec%0d frame_err@4", i), e4, 8'h00);
            checkOutput($sformatf("vec%0d ready", i), r4, vecs[i].expReady);
            checkOutput($sformatf("vec%0d data", i), d4, vecs[i].expData);
            read_enable = 1'b1;
            @(negedge clk);
            read_enable = 1'b0;
            checkOutput($sformatf("vec%0d popped ready", i), ready, 8'h00);
            checkOutput($sformatf("vec%0d popped data", i), data, 8'h00);
        end

        // Two bytes queued in order
        applyStimulus(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, e3, e4, r4, o4, d4);
        applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, e3, e4, r4, o4, d4);
        checkOutput("seq2 head", d4, 8'hF0);
        popExpect("seq2 first", 8'hF0);
        popExpect("seq2 second", 8'h1C);
        checkOutput("seq2 empty", ready, 8'h00);

        // Fill the FIFO, then overflow it with a ninth byte
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(8'(k), 1'b0, 1'b0, 1'b0, 1'b0, e3, e4, r4, o4, d4);
            if (k == 8) checkOutput("fill8 overflow", o4, 8'h00);
        end
        checkOutput("ovf flag", o4, 8'h01);
        checkOutput("ovf head", d4, 8'h01);
        read_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'b0;
        checkOutput("ovf cleared", overflow, 8'h00);
        checkOutput("ovf next head", data, 8'h02);
        applyStimulus(8'h0A, 1'b0, 1'b0, 1'b0, 1'b0, e3, e4, r4, o4, d4);
        checkOutput("refill overflow", o4, 8'h00);
        applyStimulus(8'h0B, 1'b0, 1'b0, 1'b0, 1'b1, e3, e4, r4, o4, d4);
        checkOutput("push+pop full overflow", o4, 8'h00);
        checkOutput("push+pop full head", d4, 8'h03);
        drainExp = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A, 8'h0B};
        for (int k = 0; k < 8; k++) begin
            popExpect($sformatf("drain%0d", k), drainExp[k]);
        end
        checkOutput("drained ready", ready, 8'h00);

        // A partial frame followed by an idle gap is discarded without frame_err
        sendPartial(8'hA5, 5);
        repeat (TIMEOUT + 10) @(negedge clk);
        checkOutput("timeout ready", ready, 8'h00);
        applyStimulus(8'h29, 1'b0, 1'b0, 1'b0, 1'b0, e3, e4, r4, o4, d4);
        checkOutput("timeout frame_err", e3, 8'h00);
        checkOutput("timeout ready after", r4, 8'h01);
        checkOutput("timeout data", d4, 8'h29);
        popExpect("timeout pop", 8'h29);

        // Reset in the middle of a frame, with a byte still queued
        applyStimulus(8'h33, 1'b0, 1'b0, 1'b0, 1'b0, e3, e4, r4, o4, d4);
        checkOutput("pre-rst queued", r4, 8'h01);
        sendPartial(8'hA5, 7);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst ready", ready, 8'h00);
        checkOutput("midrst overflow", overflow, 8'h00);
        checkOutput("midrst data", data, 8'h00);
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, e3, e4, r4, o4, d4);
        checkOutput("midrst frame_err", e3, 8'h00);
        checkOutput("midrst next ready", r4, 8'h01);
        checkOutput("midrst next data", d4, 8'h5A);
        popExpect("midrst pop", 8'h5A);
        checkOutput("final empty", ready, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver feeding the MMIO keyboard registers (ready flag at 0xfbadbeee, data at 0xfbadbeef).
- Synchronises the external ps2_clk/ps2_data pair and deframes 11-bit PS/2 device-to-host frames.
- Queues received scan-code bytes in a small FIFO.
- Presents the FIFO head, a ready flag and a sticky overflow flag to the MMIO block.
- Pops one byte per read_enable pulse, which MMIO issues the cycle after a byte load from 0xfbadbeef.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries (default 8).
TIMEOUT_CYCLES, 50000, clk cycles with no ps2_clk falling edge before a partial frame is discarded (about 1 ms at 50 MHz).

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  reset, asynchronous, active-high.
ps2_clk  input  1  raw PS/2 clock from pad; asynchronous to clk.
ps2_data  input  1  raw PS/2 data from pad; asynchronous to clk.
read_enable  input  1  single-cycle pop request (driven by MMIO kbd_read_enable).
ready  output  1  FIFO non-empty.
overflow  output  1  sticky: a valid byte was dropped because the FIFO was full.
data  output  8  FIFO head byte; 8'h00 when empty.
frame_err  output  1  one-cycle pulse when a completed frame is rejected.

Behaviour:
- Reset (async assert, sync release): bit counter 0, shift register 0, FIFO empty, timeout counter 0. Outputs: ready=0, overflow=0, data=8'h00, frame_err=0. Synchroniser flops reset to 1 (bus idle).
- Synchroniser: two flops per line, plus a third flop on ps2_clk. A falling edge is detected when stage2=0 and stage3=1, i.e. 3 clk after the pad edge. ps2_data is sampled from its stage2 in that same cycle.
- Bit counter runs 0..10 and advances on each falling edge:
  - bit 0: start bit, expected 0.
  - bits 1-8: data, LSB first, shifted in.
  - bit 9: parity (odd over data+parity).
  - bit 10: stop bit, expected 1.
- Frame acceptance, on the edge that captures bit 10:
  - Frame is valid iff start=0, stop=1 and parity is acceptable (see Optional Feature).
  - Valid frame -> push the byte.
  - Invalid frame -> no push; frame_err=1 for exactly the following cycle.
  - Counter returns to 0 in either case.
- Timeout: the counter clears on every falling edge and otherwise increments while bit counter != 0. When it reaches TIMEOUT_CYCLES: bit counter -> 0, partial frame discarded, no frame_err, no push.
- Latency: pushed byte appears on data, with ready=1, on the cycle after the push edge, i.e. 4 clk after the stop-bit falling edge at the pad.
- FIFO: registered read/write pointers, each FIFO_AW+1 bits wide with a wrap bit.
  - empty = pointers equal.
  - full = low bits equal and wrap bits differ.
  - data is driven combinationally from mem[rd_ptr] when non-empty.
- Pop: read_enable=1 and FIFO non-empty -> rd_ptr++. read_enable on an empty FIFO is ignored (no pointer change, no error).
- Push when full:
  - No simultaneous pop -> byte dropped, overflow <= 1.
  - Simultaneous pop -> both occur, count unchanged, no overflow.
- Push and pop in the same cycle with FIFO empty: push occurs; pop is ignored (nothing to pop yet).
- overflow clears on any read_enable cycle. A new drop in the same cycle takes priority and leaves overflow=1.
- Reset mid-frame or mid-FIFO: everything returns to reset state immediately; no partial byte is pushed after release.

Optional Feature:
- Macro: KBD_PARITY_CHECK_EN.
- Defined: a frame whose odd parity fails is rejected (frame_err pulse, no push).
- Undefined: the parity bit is shifted in and ignored; only start/stop are checked. frame_err never fires for parity alone.

Test Plan:
- Reset, then send frame for 8'h1C (start 0, data LSB-first 0,0,1,1,1,0,0,0, parity 0, stop 1) -> exactly 4 clk after stop edge: ready=1, data=8'h1C, frame_err=0; pulse read_enable -> next cycle ready=0, data=8'h00.
- Send 8'hF0 then 8'h1C (parity 1, then 0) without reading -> data=8'hF0; after one read_enable data=8'h1C; after a second, ready=0.
- Send 9 valid bytes 8'h01..8'h09 with FIFO_AW=3, no reads -> after the 9th, overflow=1 and FIFO holds 8'h01..8'h08. One read_enable -> overflow=0, data=8'h02. A 9th push in the same cycle as a pop -> overflow stays 0.
- Send 8'h1C with parity bit flipped to 1 -> KBD_PARITY_CHECK_EN defined: frame_err pulses 1 cycle, ready stays 0. Undefined: ready=1, data=8'h1C.
- Send 5 bits then idle TIMEOUT_CYCLES+10 clk, then a full frame for 8'h29 -> ready=1, data=8'h29, no frame_err.
- Assert rst after bit 6 of a frame and release 2 cycles later -> ready=0, overflow=0, data=8'h00; the next complete frame 8'h5A is received correctly.
